fcmp_pipe: RTL and testbench

Pipelined, parametrised floating-point compare unit for the FPU: evaluates EQ, LT or LE on two IEEE-754-style operands of configurable exponent and mantissa width. It sits behind the FPU issue stage and accepts one operation per cycle with valid/ready flow control. It returns a 1-bit result plus an invalid-operation flag, carries a caller tag, and keeps a sticky invalid flag for the fcsr.

---
 rtl/fpu_pkg.sv | 58 +++++
 rtl/fcmp_pipe_if.sv | 38 +++
 rtl/fcmp_stage.sv | 40 ++++
 rtl/fcmp_pipe.sv | 119 +++++++++++
 tb/tb_fcmp_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FPU definitions: compare-mode encoding, per-operand class bits and a
// classifier that works for any exponent/mantissa split up to FP_MAX_W bits.
// -----------------------------------------------------------------------------
package fpu_pkg;

    // Widest operand the classifier accepts (sign + exponent + mantissa).
    localparam int FP_MAX_W = 128;

    typedef enum logic [1:0] {
        FCMP_EQ   = 2'd0,
        FCMP_LT   = 2'd1,
        FCMP_LE   = 2'd2,
        FCMP_RSVD = 2'd3
    } fcmp_mode_t;

    typedef struct packed {
        logic sign;
        logic nan;
        logic snan;
        logic zero;
    } fp_class_t;

    localparam int FP_CLASS_W = $bits(fp_class_t);

    // Operand must be zero-extended to FP_MAX_W; exp_w/man_w are elaboration
    // constants at every call site, so the loop reduces to plain wiring.
    function automatic fp_class_t fp_classify(input logic [FP_MAX_W-1:0] x,
                                              input int exp_w,
                                              input int man_w);
        fp_class_t c;
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        logic man_msb;
        exp_ones = 1'b1;
        exp_zero = 1'b1;
        man_zero = 1'b1;
        man_msb  = 1'b0;
        c        = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i < man_w) begin
                man_zero = man_zero & ~x[i];
            end else if (i < man_w + exp_w) begin
                exp_ones = exp_ones & x[i];
                exp_zero = exp_zero & ~x[i];
            end
            if (i == man_w - 1)     man_msb = x[i];
            if (i == man_w + exp_w) c.sign  = x[i];
        end
        c.nan  = exp_ones & ~man_zero;
        c.snan = c.nan & ~man_msb;
        c.zero = exp_zero & man_zero;
        return c;
    endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// -----------------------------------------------------------------------------
// fcmp_pipe_if
// Issue-side and result-side handshake bundle of the FP compare unit, plus the
// sticky invalid flag and its clear.
//   slave  : compare unit view (accepts operations, produces results)
//   master : issuing/consuming side view
// -----------------------------------------------------------------------------
interface fcmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [W-1:0]     in_x1;
    logic [W-1:0]     in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic             out_exception;
    logic [TAG_W-1:0] out_tag;
    logic             nv_sticky;
    logic             nv_clear;

    modport slave (
        input  in_valid, in_mode, in_x1, in_x2, in_tag, out_ready, nv_clear,
        output in_ready, out_valid, out_y, out_exception, out_tag, nv_sticky
    );

    modport master (
        output in_valid, in_mode, in_x1, in_x2, in_tag, out_ready, nv_clear,
        input  in_ready, out_valid, out_y, out_exception, out_tag, nv_sticky
    );
endinterface

// File: rtl/fcmp_stage.sv
// -----------------------------------------------------------------------------
// fcmp_stage
// One-entry pipeline register with valid/ready flow control.
//   clk, rstn              : clock, synchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_data_o payload
// in_ready_o is combinational from out_ready_i so a full chain streams at
// one transfer per cycle without bubbles.
// -----------------------------------------------------------------------------
module fcmp_stage #(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [P-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [P-1:0] out_data_o
);
    logic         valid_q;
    logic [P-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            // Payload only moves on a real transfer so an idle stage keeps
            // its last value instead of sampling undriven inputs.
            if (in_valid_i) data_q <= in_data_i;
        end
    end
endmodule

// File: rtl/fcmp_pipe.sv
// -----------------------------------------------------------------------------
// fcmp_pipe
// Two-stage floating-point compare (EQ / LT / LE) with valid/ready flow control,
// pass-through tag and a sticky invalid-operation flag for the fcsr.
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : fcmp_pipe_if.slave -- in_* operation, out_* result, nv_* sticky
// S1 holds mode, tag, operand classes and the unsigned magnitude compares;
// S2 holds the final y/exception/tag and drives the out_* signals.
// -----------------------------------------------------------------------------
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rstn,
    fcmp_pipe_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P1 = 2 + TAG_W + 2 * FP_CLASS_W + 2;
    localparam int P2 = 2 + TAG_W;

    logic [FP_MAX_W-1:0] x1_ext_p0, x2_ext_p0;
    fp_class_t           c1_p0, c2_p0;
    logic                mag_lt_p0, mag_eq_p0;
    logic [P1-1:0]       s1_d, s1_q;

    logic                vld_p1, s2_ready;
    logic [1:0]          mode_p1;
    logic [TAG_W-1:0]    tag_p1;
    fp_class_t           c1_p1, c2_p1;
    logic                mag_lt_p1, mag_eq_p1;
    logic                nan_p1, snan_p1, zero_p1, eq_p1, lt_p1, y_p1, exc_p1;
    logic [P2-1:0]       s2_d, s2_q;

    logic                nv_d, nv_q;

    // ---- p0: classify operands, unsigned magnitude compares -> S1 ----
    always_comb begin
        x1_ext_p0        = '0;
        x2_ext_p0        = '0;
        x1_ext_p0[W-1:0] = bus.in_x1;
        x2_ext_p0[W-1:0] = bus.in_x2;
        c1_p0            = fp_classify(x1_ext_p0, EXP_W, MAN_W);
        c2_p0            = fp_classify(x2_ext_p0, EXP_W, MAN_W);
        mag_lt_p0        = bus.in_x1[W-2:0] <  bus.in_x2[W-2:0];
        mag_eq_p0        = bus.in_x1[W-2:0] == bus.in_x2[W-2:0];
    end

    assign s1_d = {bus.in_mode, bus.in_tag, c1_p0, c2_p0, mag_lt_p0, mag_eq_p0};

    fcmp_stage #(.P(P1)) u_s1 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (s1_d),
        .out_valid_o (vld_p1),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_q)
    );

    // ---- p1: resolve the compare from class bits -> S2 ----
    assign {mode_p1, tag_p1, c1_p1, c2_p1, mag_lt_p1, mag_eq_p1} = s1_q;

    always_comb begin
        nan_p1  = c1_p1.nan | c2_p1.nan;
        snan_p1 = c1_p1.snan | c2_p1.snan;
        zero_p1 = c1_p1.zero & c2_p1.zero;
        // Identical patterns = same sign and same magnitude bits.
        eq_p1   = !nan_p1 && (zero_p1 || ((c1_p1.sign == c2_p1.sign) && mag_eq_p1));
        if (nan_p1 || zero_p1)          lt_p1 = 1'b0;
        else if (c1_p1.sign != c2_p1.sign) lt_p1 = c1_p1.sign;
        else if (!c1_p1.sign)           lt_p1 = mag_lt_p1;
        else                            lt_p1 = !mag_lt_p1 && !mag_eq_p1;

        y_p1   = 1'b0;
        exc_p1 = 1'b0;
        case (fcmp_mode_t'(mode_p1))
            FCMP_EQ: begin y_p1 = eq_p1;         exc_p1 = snan_p1; end
            FCMP_LT: begin y_p1 = lt_p1;         exc_p1 = nan_p1;  end
            FCMP_LE: begin y_p1 = lt_p1 | eq_p1; exc_p1 = nan_p1;  end
            default: begin y_p1 = 1'b0;          exc_p1 = 1'b0;    end
        endcase
    end

    assign s2_d = {y_p1, exc_p1, tag_p1};

    fcmp_stage #(.P(P2)) u_s2 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (vld_p1),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_d),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (s2_q)
    );

    // ---- p2: result outputs and sticky invalid flag ----
    assign {bus.out_y, bus.out_exception, bus.out_tag} = s2_q;

    always_comb begin
        nv_d = nv_q;
        if (bus.nv_clear) nv_d = 1'b0;
        // A flag raised by an accepted result beats a clear in the same cycle.
        if (bus.out_valid && bus.out_ready && bus.out_exception) nv_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) nv_q <= 1'b0;
        else       nv_q <= nv_d;
    end

    assign bus.nv_sticky = nv_q;
endmodule

// File: tb/tb_fcmp_pipe.sv
module tb_fcmp_pipe;
    import fpu_pkg::*;

    typedef struct packed {
        logic       y;
        logic       exc;
        logic [4:0] tag;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    res_t exp_q[$];
    res_t obs_q[$];
    int   acc_cyc[$];
    int   out_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fcmp_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) bus ();
    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    fcmp_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) bus_d ();
    fcmp_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) dut_d (
        .clk(clk), .rstn(rstn), .bus(bus_d)
    );

    // ---------------- reference model (real-number semantics) ----------------
    function automatic real f32_val(input logic [31:0] b);
        int  e;
        real m;
        real mag;
        e = int'(b[30:23]);
        m = real'(b[22:0]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = m * (2.0 ** (-149));
        else             mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -mag : mag;
    endfunction

    function automatic logic [1:0] ref_cmp(input logic [1:0] mode, input bit na, input bit nb,
                                           input bit sa, input bit sb, input real ra, input real rb);
        case (mode)
            2'd0:    return {!(na || nb) && (ra == rb), sa || sb};
            2'd1:    return {!(na || nb) && (ra <  rb), na || nb};
            2'd2:    return {!(na || nb) && (ra <= rb), na || nb};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ref32(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
        bit na, nb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        return ref_cmp(mode, na, nb, na && !a[22], nb && !b[22], f32_val(a), f32_val(b));
    endfunction

    function automatic logic [1:0] ref64(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b);
        bit na, nb;
        na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        return ref_cmp(mode, na, nb, na && !a[51], nb && !b[51],
                       na ? 0.0 : $bitstoreal(a), nb ? 0.0 : $bitstoreal(b));
    endfunction

    function automatic logic [31:0] rnd32(input logic [31:0] other);
        logic [31:0] sp [10] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                 32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'hBF800000,
                                 32'h00000001, 32'h80000001};
        case ($urandom_range(0, 5))
            0, 1:    return sp[$urandom_range(0, 9)];
            2:       return other;
            3:       return other ^ 32'h1;
            4:       return {other[31:23], 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] rnd64(input logic [63:0] other);
        logic [63:0] sp [6] = '{64'h0, 64'h8000000000000000, 64'h7FF0000000000000,
                                64'h7FF8000000000000, 64'h7FF0000000000001, 64'hBFF0000000000000};
        case ($urandom_range(0, 4))
            0:       return sp[$urandom_range(0, 5)];
            1:       return other;
            2:       return other ^ 64'h1;
            3:       return {other[63:52], 20'($urandom), 32'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- handshake recorders (sampled mid-cycle) ----------------
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({ref32(bus.in_mode, bus.in_x1, bus.in_x2), bus.in_tag});
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back({bus.out_y, bus.out_exception, bus.out_tag});
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        obs_q.delete();
        acc_cyc.delete();
        out_cyc.delete();
    endtask

    task automatic drive_rand(input logic [4:0] tag);
        logic [31:0] a;
        a = rnd32($urandom);
        bus.in_mode = 2'($urandom_range(0, 3));
        bus.in_x1   = a;
        bus.in_x2   = rnd32(a);
        bus.in_tag  = tag;
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output res_t r, output bit to);
        int k;
        bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_x1 = a; bus.in_x2 = b; bus.in_tag = tag;
        bus.out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 10) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 10) begin @(negedge clk); k++; end
        to = !bus.out_valid;
        r  = {bus.out_y, bus.out_exception, bus.out_tag};
        @(posedge clk); #1;
    endtask

    task automatic run_op64(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag, output res_t r, output bit to);
        int k;
        bus_d.in_valid = 1'b1; bus_d.in_mode = mode; bus_d.in_x1 = a; bus_d.in_x2 = b; bus_d.in_tag = tag;
        bus_d.out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus_d.in_ready && k < 10) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus_d.in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!bus_d.out_valid && k < 10) begin @(negedge clk); k++; end
        to = !bus_d.out_valid;
        r  = {bus_d.out_y, bus_d.out_exception, bus_d.out_tag};
        @(posedge clk); #1;
    endtask

    // ---------------------------- scenarios ----------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        n_cmp++; if (bus.out_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_y !== 1'b0)         begin n_fail++; $display("FAIL reset_out_y: got %b want 0", bus.out_y); end
        n_cmp++; if (bus.out_exception !== 1'b0) begin n_fail++; $display("FAIL reset_out_exc: got %b want 0", bus.out_exception); end
        n_cmp++; if (bus.out_tag !== 5'd0)       begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
        n_cmp++; if (bus.nv_sticky !== 1'b0)     begin n_fail++; $display("FAIL reset_nv_sticky: got %b want 0", bus.nv_sticky); end
        n_cmp++; if (bus.in_ready !== 1'b1)      begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [1:0]  md [12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3};
        logic [31:0] xa [12] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000,
                                 32'h7FC00000, 32'h7FC00000, 32'h7F800001, 32'hC0000000,
                                 32'hBF800000, 32'h40000000, 32'h00000001, 32'h3F800000};
        logic [31:0] xb [12] = '{32'h3F800000, 32'h80000000, 32'h80000000, 32'h80000000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                                 32'h3F800000, 32'h3F800000, 32'h00000002, 32'h3F800000};
        logic        ey [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ee [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        res_t r;
        bit   to;
        for (int i = 0; i < 12; i++) begin
            run_op(md[i], xa[i], xb[i], 5'(i), r, to);
            n_cmp++;
            if (to || r !== {ey[i], ee[i], 5'(i)}) begin
                n_fail++;
                $display("FAIL directed_%0d: got y=%b exc=%b tag=%0d timeout=%b want y=%b exc=%b tag=%0d",
                         i, r.y, r.exc, r.tag, to, ey[i], ee[i], i);
            end
            if (i == 4) begin
                n_cmp++; if (bus.nv_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_after_qnan_eq: got %b want 0", bus.nv_sticky); end
            end
            if (i == 5) begin
                n_cmp++; if (bus.nv_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_after_qnan_lt: got %b want 1", bus.nv_sticky); end
            end
        end
    endtask

    task automatic test_back_to_back();
        flush();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            drive_rand(5'(i));
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_%0d: got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (obs_q.size() != 10 || exp_q.size() != 10) begin
            n_fail++; $display("FAIL b2b_count: got %0d results / %0d accepts want 10", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 5'(i)) begin
                    n_fail++; $display("FAIL b2b_result_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
                n_cmp++;
                if (out_cyc[i] - acc_cyc[i] != 2 || out_cyc[i] != out_cyc[0] + i) begin
                    n_fail++; $display("FAIL b2b_latency_%0d: got accept %0d result %0d want latency 2 one per cycle",
                                       i, acc_cyc[i], out_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        res_t snap, cur;
        bit   have;
        bit   took;
        int   acc;
        flush();
        bus.nv_clear = 1'b1; tick(); bus.nv_clear = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode = 2'd1; bus.in_x1 = 32'h7FC00000; bus.in_x2 = 32'h0; bus.in_tag = 5'd20;
        have = 1'b0; acc = 0; snap = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cur = {bus.out_y, bus.out_exception, bus.out_tag};
            if (bus.out_valid) begin
                if (!have) begin snap = cur; have = 1'b1; end
                else begin
                    n_cmp++; if (cur !== snap) begin n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", c, cur, snap); end
                end
            end
            took = bus.in_ready;
            @(posedge clk); #1;
            if (took) begin acc++; drive_rand(5'(20 + acc)); end
        end
        n_cmp++; if (acc != 2)              begin n_fail++; $display("FAIL stall_accepts: got %0d want 2", acc); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.nv_sticky !== 1'b0) begin n_fail++; $display("FAIL stall_sticky_pre: got %b want 0", bus.nv_sticky); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.nv_clear = 1'b1;
        tick();
        bus.nv_clear = 1'b0;
        n_cmp++; if (bus.nv_sticky !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b want 1", bus.nv_sticky); end
        repeat (3) tick();
        n_cmp++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL stall_count: got %0d results / %0d accepts want 2", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_result_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
            n_cmp++; if (obs_q[0] !== {1'b0, 1'b1, 5'd20}) begin n_fail++; $display("FAIL stall_first: got %h want %h", obs_q[0], {1'b0, 1'b1, 5'd20}); end
        end
    endtask

    task automatic test_random();
        int n;
        flush();
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            drive_rand(5'(c));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_result_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        res_t r;
        bit   to;
        flush();
        run_op(2'd1, 32'h7FC00000, 32'h3F800000, 5'd3, r, to);
        n_cmp++; if (bus.nv_sticky !== 1'b1) begin n_fail++; $display("FAIL midrst_sticky_pre: got %b want 1", bus.nv_sticky); end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_rand(5'd9);
        repeat (3) tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_full: got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
        end
        rstn = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.nv_sticky !== 1'b0) begin n_fail++; $display("FAIL midrst_sticky: got %b want 0", bus.nv_sticky); end
        n_cmp++; if ({bus.out_y, bus.out_exception, bus.out_tag} !== 7'd0) begin
            n_fail++; $display("FAIL midrst_out_data: got %b%b%h want 0", bus.out_y, bus.out_exception, bus.out_tag);
        end
        flush();
        rstn = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (obs_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_discard: got %0d results out_valid=%b want 0/0", obs_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_double();
        logic [1:0]  md [3] = '{2'd1, 2'd0, 2'd2};
        logic [63:0] xa [3] = '{64'hBFF0000000000000, 64'h0, 64'h7FF8000000000000};
        logic [63:0] xb [3] = '{64'h0, 64'h8000000000000000, 64'h0};
        logic        ey [3] = '{1'b1, 1'b1, 1'b0};
        logic        ee [3] = '{1'b0, 1'b0, 1'b1};
        logic [63:0] a, b;
        logic [1:0]  m, e;
        res_t r;
        bit   to;
        for (int i = 0; i < 3; i++) begin
            run_op64(md[i], xa[i], xb[i], 5'(i), r, to);
            n_cmp++;
            if (to || r !== {ey[i], ee[i], 5'(i)}) begin
                n_fail++; $display("FAIL double_directed_%0d: got %h timeout=%b want %h", i, r, to, {ey[i], ee[i], 5'(i)});
            end
        end
        for (int i = 0; i < 20; i++) begin
            a = rnd64({$urandom, $urandom});
            b = rnd64(a);
            m = 2'($urandom_range(0, 3));
            e = ref64(m, a, b);
            run_op64(m, a, b, 5'(i + 8), r, to);
            n_cmp++;
            if (to || r !== {e, 5'(i + 8)}) begin
                n_fail++; $display("FAIL double_random_%0d: mode %0d x1 %h x2 %h got %h want %h", i, m, a, b, r, {e, 5'(i + 8)});
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_x1 = '0; bus.in_x2 = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1; bus.nv_clear = 1'b0;
        bus_d.in_valid = 1'b0; bus_d.in_mode = 2'd0; bus_d.in_x1 = '0; bus_d.in_x2 = '0; bus_d.in_tag = '0;
        bus_d.out_ready = 1'b1; bus_d.nv_clear = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        test_double();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
